// File: rtl/pwm_pkg.sv
// Shared constants, configuration struct and PWM level helper for pwm_peripheral.
package pwm_pkg;

  localparam int unsigned DIV_DEFAULT = 13;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned OUT_W       = 16;

  localparam logic [CNT_W-1:0] CNT_MAX   = 8'hFF;
  localparam logic [CNT_W-1:0] DUTY_OFF  = 8'h00;
  localparam logic [CNT_W-1:0] DUTY_FULL = 8'hFF;

  // Output bit i is controlled by bit i of {reg_15_8, reg_7_0}; every bit is populated.
  localparam logic [OUT_W-1:0] OUT_IDX_MAP = 16'hFFFF;

  typedef struct packed {
    logic [OUT_W-1:0] en_out;
    logic [OUT_W-1:0] en_pwm;
    logic [CNT_W-1:0] duty;
  } pwm_cfg_t;

  // 0 and FF are pinned so that FF means a true 100% rather than 255/256.
  function automatic logic pwm_level(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] duty);
    logic lvl;
    if (duty == DUTY_OFF)
      lvl = 1'b0;
    else if (duty == DUTY_FULL)
      lvl = 1'b1;
    else
      lvl = (cnt < duty);
    return lvl;
  endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// Configuration-register inputs and PWM outputs of pwm_peripheral, bundled as one interface.
interface pwm_peripheral_if;
  import pwm_pkg::*;

  logic [7:0]       en_reg_out_7_0;
  logic [7:0]       en_reg_out_15_8;
  logic [7:0]       en_reg_pwm_7_0;
  logic [7:0]       en_reg_pwm_15_8;
  logic [7:0]       pwm_duty_cycle;
  logic [OUT_W-1:0] out;
  logic             period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output out, period_start
  );

endinterface

// File: rtl/pwm_prescaler.sv
// Divide-by-DIV prescaler: tick is high for the one cycle in DIV where pre_q == DIV-1.
module pwm_prescaler #(
  parameter int unsigned DIV   = 13,
  parameter int unsigned PRE_W = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      pre_q <= '0;
    else
      pre_q <= pre_d;
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-output PWM peripheral driven from captured config registers.
// Define PWM_SHADOW_EN to load the active duty only at the period wrap (glitch-free updates).
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned DIV   = DIV_DEFAULT,
  parameter int unsigned PRE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  pwm_peripheral_if.slave   bus
);

  pwm_cfg_t         cfg_q, cfg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ps_q, ps_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] duty_act;
  logic             tick;
  logic             wrap;
  logic             pwm_sig;

  pwm_prescaler #(
    .DIV   (DIV),
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

`ifdef PWM_SHADOW_EN
  logic [CNT_W-1:0] duty_q, duty_d;

  always_comb begin
    duty_d = wrap ? cfg_q.duty : duty_q;
  end

  always_ff @(posedge clk) begin
    if (rst)
      duty_q <= '0;
    else
      duty_q <= duty_d;
  end

  assign duty_act = duty_q;
`else
  assign duty_act = cfg_q.duty;
`endif

  // Config is quasi-static, so a single capture stage is enough; no synchroniser.
  always_comb begin
    cfg_d.en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    cfg_d.en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    cfg_d.duty   = bus.pwm_duty_cycle;
  end

  always_comb begin
    wrap    = tick && (cnt_q == CNT_MAX);
    cnt_d   = tick ? cnt_q + CNT_W'(1) : cnt_q;
    ps_d    = wrap;
    pwm_sig = pwm_level(cnt_q, duty_act);
    out_d   = OUT_IDX_MAP & cfg_q.en_out & (~cfg_q.en_pwm | {OUT_W{pwm_sig}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q <= '0;
      cnt_q <= '0;
      ps_q  <= 1'b0;
      out_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      cnt_q <= cnt_d;
      ps_q  <= ps_d;
      out_q <= out_d;
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = ps_q;

endmodule
